// File: rtl/uart_pkg.sv
// Shared definitions for the parameterised UART receiver.
//   state_t   : receiver FSM states
//   PAR_*     : parity mode encodings for the PARITY parameter
//   calc_div  : clocks per 1/16-bit tick, rounded to nearest
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   localparam int PAR_NONE = 0;
   localparam int PAR_ODD  = 1;
   localparam int PAR_EVEN = 2;

   // round(clk_hz / (baud * 16)) using integer arithmetic
   function automatic int calc_div(input int clk_hz, input int baud);
      return (clk_hz + baud * 8) / (baud * 16);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-cycle tick every DIV clocks.
//   clk     : system clock
//   rst     : asynchronous active-high reset
//   restart : realigns the divider so the next tick comes DIV clocks later
//   tick    : one-cycle pulse at the 16x bit rate
module uart_baud_tick #(
   parameter int DIV = 10
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [CW-1:0] cnt;

   assign tick = (cnt == CW'(DIV - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (restart || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver with 16x oversampling and majority voting.
//   clk, rst      : system clock, asynchronous active-high reset
//   rx            : asynchronous serial input (idle high)
//   data          : received payload, LSB first on the line
//   data_valid    : payload available, held until data_ready handshake
//   data_ready    : consumer accept
//   parity_err    : parity mismatch for the current payload
//   frame_err     : a stop bit was sampled low for the current payload
//   overrun       : sticky, a frame landed while data_valid was still high
//   overrun_clr   : clears overrun (a simultaneous new overrun wins)
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int CLK_HZ    = 66_000_000,
   parameter int BAUD      = 9_600,
   parameter int DATA_BITS = 8,
   parameter int PARITY    = 0,
   parameter int STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 data_valid,
   input  logic                 data_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   input  logic                 overrun_clr
);

   localparam int DIV = calc_div(CLK_HZ, BAUD);

   if (DIV < 2) begin : g_bad_div
      $error("uart_rx_param: DIV must be at least 2");
   end
   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_bits
      $error("uart_rx_param: DATA_BITS must be 5..9");
   end
   if (PARITY < 0 || PARITY > 2) begin : g_bad_par
      $error("uart_rx_param: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
      $error("uart_rx_param: STOP_BITS must be 1 or 2");
   end

   localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
   localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

   logic                 sync1;
   logic                 rx_s;
   logic                 rx_prev;
   logic                 fall;
   logic                 restart;
   logic                 tick;
   logic                 maj;
   state_t               state;
   logic [3:0]           sub;
   logic [3:0]           bit_cnt;
   logic                 stop_cnt;
   logic [DATA_BITS-1:0] shift;
   logic                 s7;
   logic                 s8;
   logic                 pbit;
   logic                 ferr_acc;
   logic                 done_p;

   function automatic logic parity_error(input logic [DATA_BITS-1:0] d,
                                         input logic                 p);
      logic calc;
      calc = (^d) ^ p;
      case (PARITY)
         PAR_ODD:  return ~calc;
         PAR_EVEN: return calc;
         default:  return 1'b0;
      endcase
   endfunction

   // rx_prev is a third stage used only for falling-edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1   <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         sync1   <= rx;
         rx_s    <= sync1;
         rx_prev <= rx_s;
      end
   end

   // A genuine 1->0 edge is required, so a line still low after a bad
   // stop bit cannot be mistaken for a new start.
   assign fall    = rx_prev & ~rx_s;
   assign restart = (state == ST_IDLE) && fall;
   assign maj     = (s7 & s8) | (s7 & rx_s) | (s8 & rx_s);

   uart_baud_tick #(
      .DIV(DIV)
   ) u_tick (
      .clk     (clk),
      .rst     (rst),
      .restart (restart),
      .tick    (tick)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         sub        <= '0;
         bit_cnt    <= '0;
         stop_cnt   <= 1'b0;
         shift      <= '0;
         s7         <= 1'b1;
         s8         <= 1'b1;
         pbit       <= 1'b0;
         ferr_acc   <= 1'b0;
         done_p     <= 1'b0;
         data       <= '0;
         data_valid <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         // Output handshake; a completing frame below overrides these.
         if (done_p) begin
            data_valid <= 1'b1;
            done_p     <= 1'b0;
         end else if (data_valid && data_ready) begin
            data_valid <= 1'b0;
         end
         if (overrun_clr) begin
            overrun <= 1'b0;
         end

         case (state)
            ST_IDLE: begin
               if (fall) begin
                  state    <= ST_START;
                  sub      <= '0;
                  stop_cnt <= 1'b0;
                  ferr_acc <= 1'b0;
               end
            end
            default: begin
               if (tick) begin
                  sub <= sub + 4'd1;
                  if (sub == 4'd7) s7 <= rx_s;
                  if (sub == 4'd8) s8 <= rx_s;
                  case (state)
                     ST_START: begin
                        if (sub == 4'd9 && maj) begin
                           state <= ST_IDLE;
                        end else if (sub == 4'd15) begin
                           state   <= ST_DATA;
                           bit_cnt <= '0;
                        end
                     end
                     ST_DATA: begin
                        if (sub == 4'd9) begin
                           shift <= {maj, shift[DATA_BITS-1:1]};
                        end
                        if (sub == 4'd15) begin
                           if (bit_cnt == LAST_BIT) begin
                              state <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                           end else begin
                              bit_cnt <= bit_cnt + 4'd1;
                           end
                        end
                     end
                     ST_PARITY: begin
                        if (sub == 4'd9) pbit <= maj;
                        if (sub == 4'd15) state <= ST_STOP;
                     end
                     ST_STOP: begin
                        if (sub == 4'd9) begin
                           if (stop_cnt == LAST_STOP) begin
                              // Frame complete: load results now, leave the
                              // stop bit early to catch a back-to-back start.
                              state      <= ST_IDLE;
                              data       <= shift;
                              parity_err <= parity_error(shift, pbit);
                              frame_err  <= ferr_acc | ~maj;
                              if (!data_valid) begin
                                 done_p <= 1'b1;
                              end else begin
                                 // Overwrite keeps valid high; without a
                                 // same-cycle accept the old payload was lost.
                                 data_valid <= 1'b1;
                                 if (!data_ready) overrun <= 1'b1;
                              end
                           end else begin
                              ferr_acc <= ferr_acc | ~maj;
                           end
                        end else if (sub == 4'd15) begin
                           stop_cnt <= 1'b1;
                        end
                     end
                     default: ;
                  endcase
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param: an 8N1 instance and an 8E1 instance.
module tb_uart_rx_param;
   import uart_pkg::*;

   localparam int BIT_CLKS = 160;

   typedef struct packed {
      logic [7:0] d;
      logic       pe;
      logic       fe;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx, data_ready, overrun_clr;
   logic [7:0] data;
   logic       data_valid, parity_err, frame_err, overrun;
   logic       rx_p, data_ready_p, overrun_clr_p;
   logic [7:0] data_p;
   logic       data_valid_p, parity_err_p, frame_err_p, overrun_p;

   int   errors = 0;
   int   checks = 0;
   exp_t q[$];
   exp_t e;

   logic       sel;
   logic       got;
   int         vcount;
   logic [7:0] cap_d;
   logic       cap_pe, cap_fe;

   always #5 clk = ~clk;

   uart_rx_param #(
      .CLK_HZ(1_600_000), .BAUD(10_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
   ) dut (
      .clk(clk), .rst(rst), .rx(rx), .data(data), .data_valid(data_valid),
      .data_ready(data_ready), .parity_err(parity_err), .frame_err(frame_err),
      .overrun(overrun), .overrun_clr(overrun_clr)
   );

   uart_rx_param #(
      .CLK_HZ(1_600_000), .BAUD(10_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)
   ) dut_p (
      .clk(clk), .rst(rst), .rx(rx_p), .data(data_p), .data_valid(data_valid_p),
      .data_ready(data_ready_p), .parity_err(parity_err_p), .frame_err(frame_err_p),
      .overrun(overrun_p), .overrun_clr(overrun_clr_p)
   );

   // Advance n clocks, sampling 1 time unit after each rising edge and
   // capturing the payload on the first valid cycle seen.
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         if (sel ? data_valid_p : data_valid) begin
            vcount++;
            if (!got) begin
               got    = 1'b1;
               cap_d  = sel ? data_p : data;
               cap_pe = sel ? parity_err_p : parity_err;
               cap_fe = sel ? frame_err_p : frame_err;
            end
         end
      end
   endtask

   task automatic set_line(input logic v);
      if (sel) rx_p = v;
      else     rx   = v;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic use_par,
                             input logic pbit, input logic stopv);
      set_line(1'b0);
      step(BIT_CLKS);
      for (int i = 0; i < 8; i++) begin
         set_line(d[i]);
         step(BIT_CLKS);
      end
      if (use_par) begin
         set_line(pbit);
         step(BIT_CLKS);
      end
      set_line(stopv);
      step(BIT_CLKS);
      set_line(1'b1);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      step(5);
      checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", data); end
      checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", data_valid); end
      checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr got=%b exp=0", parity_err); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got=%b exp=0", frame_err); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr got=%b exp=0", overrun); end
      checks++; if (data_valid_p !== 1'b0) begin errors++; $display("FAIL reset_valid_p got=%b exp=0", data_valid_p); end
      checks++; if (dut.state !== ST_IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dut.state, ST_IDLE); end
      rst = 1'b0;
      step(20);
   endtask

   task automatic test_basic;
      sel = 1'b0; got = 1'b0; vcount = 0;
      q.push_back('{d: 8'hA5, pe: 1'b0, fe: 1'b0});
      send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
      step(40);
      checks++;
      if (!got) begin
         errors++; $display("FAIL basic_timeout got=no_valid exp=valid");
      end else begin
         e = q.pop_front();
         checks++; if (cap_d !== e.d) begin errors++; $display("FAIL basic_data got=%h exp=%h", cap_d, e.d); end
         checks++; if (cap_pe !== e.pe) begin errors++; $display("FAIL basic_perr got=%b exp=%b", cap_pe, e.pe); end
         checks++; if (cap_fe !== e.fe) begin errors++; $display("FAIL basic_ferr got=%b exp=%b", cap_fe, e.fe); end
      end
      checks++; if (vcount != 1) begin errors++; $display("FAIL basic_valid_len got=%0d exp=1", vcount); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL basic_ovr got=%b exp=0", overrun); end
   endtask

   task automatic test_parity;
      logic [7:0] d;
      logic       pb;
      sel = 1'b1;
      d   = 8'h03;
      for (int k = 0; k < 2; k++) begin
         pb = (k == 0);
         got = 1'b0; vcount = 0;
         // even parity: error when data XOR parity bit is 1
         q.push_back('{d: d, pe: (^d) ^ pb, fe: 1'b0});
         send_frame(d, 1'b1, pb, 1'b1);
         step(40);
         checks++;
         if (!got) begin
            errors++; $display("FAIL parity_timeout pbit=%b got=no_valid exp=valid", pb);
         end else begin
            e = q.pop_front();
            checks++; if (cap_d !== e.d) begin errors++; $display("FAIL parity_data pbit=%b got=%h exp=%h", pb, cap_d, e.d); end
            checks++; if (cap_pe !== e.pe) begin errors++; $display("FAIL parity_perr pbit=%b got=%b exp=%b", pb, cap_pe, e.pe); end
            checks++; if (cap_fe !== e.fe) begin errors++; $display("FAIL parity_ferr pbit=%b got=%b exp=%b", pb, cap_fe, e.fe); end
         end
      end
      sel = 1'b0;
   endtask

   task automatic test_frame_err;
      sel = 1'b0;
      q.push_back('{d: 8'h3C, pe: 1'b0, fe: 1'b1});
      q.push_back('{d: 8'h55, pe: 1'b0, fe: 1'b0});
      for (int k = 0; k < 2; k++) begin
         got = 1'b0; vcount = 0;
         if (k == 0) send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
         else        send_frame(8'h55, 1'b0, 1'b0, 1'b1);
         step(2 * BIT_CLKS);
         checks++;
         if (!got) begin
            errors++; $display("FAIL ferr_timeout frame=%0d got=no_valid exp=valid", k);
         end else begin
            e = q.pop_front();
            checks++; if (cap_d !== e.d) begin errors++; $display("FAIL ferr_data frame=%0d got=%h exp=%h", k, cap_d, e.d); end
            checks++; if (cap_fe !== e.fe) begin errors++; $display("FAIL ferr_flag frame=%0d got=%b exp=%b", k, cap_fe, e.fe); end
         end
      end
   endtask

   task automatic test_false_start;
      sel = 1'b0; got = 1'b0; vcount = 0;
      set_line(1'b0);
      step(60);
      set_line(1'b1);
      step(3 * BIT_CLKS);
      checks++; if (vcount != 0) begin errors++; $display("FAIL false_start_valid got=%0d exp=0", vcount); end
      checks++; if (dut.state !== ST_IDLE) begin errors++; $display("FAIL false_start_state got=%0d exp=%0d", dut.state, ST_IDLE); end
   endtask

   task automatic test_back_to_back;
      sel = 1'b0; got = 1'b0; vcount = 0;
      data_ready = 1'b0;
      q.push_back('{d: 8'h11, pe: 1'b0, fe: 1'b0});
      q.push_back('{d: 8'h22, pe: 1'b0, fe: 1'b0});
      send_frame(8'h11, 1'b0, 1'b0, 1'b1);
      send_frame(8'h22, 1'b0, 1'b0, 1'b1);
      step(40);
      checks++;
      if (!got) begin
         errors++; $display("FAIL b2b_timeout got=no_valid exp=valid");
      end else begin
         e = q.pop_front();
         checks++; if (cap_d !== e.d) begin errors++; $display("FAIL b2b_first got=%h exp=%h", cap_d, e.d); end
      end
      if (q.size() > 0) begin
         e = q.pop_front();
         checks++; if (data !== e.d) begin errors++; $display("FAIL b2b_second got=%h exp=%h", data, e.d); end
      end
      checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got=%b exp=1", data_valid); end
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL b2b_ovr_set got=%b exp=1", overrun); end
      overrun_clr = 1'b1;
      step(1);
      overrun_clr = 1'b0;
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_ovr_clr got=%b exp=0", overrun); end
      checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_hold got=%b exp=1", data_valid); end
      data_ready = 1'b1;
      step(1);
      checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL b2b_accept got=%b exp=0", data_valid); end
      step(20);
   endtask

   task automatic test_reset_midframe;
      logic [7:0] d;
      sel = 1'b0; got = 1'b0; vcount = 0;
      d = 8'h7E;
      set_line(1'b0);
      step(BIT_CLKS);
      for (int i = 0; i < 4; i++) begin
         set_line(d[i]);
         step(BIT_CLKS);
      end
      set_line(d[4]);
      step(BIT_CLKS / 2);
      rst = 1'b1;
      #1;
      checks++; if (data !== 8'h00) begin errors++; $display("FAIL midrst_data got=%h exp=00", data); end
      checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b exp=0", data_valid); end
      checks++; if (dut.state !== ST_IDLE) begin errors++; $display("FAIL midrst_state got=%0d exp=%0d", dut.state, ST_IDLE); end
      step(4);
      rst = 1'b0;
      set_line(1'b1);
      vcount = 0;
      step(2 * BIT_CLKS);
      checks++; if (vcount != 0) begin errors++; $display("FAIL midrst_no_pulse got=%0d exp=0", vcount); end
      got = 1'b0;
      q.push_back('{d: 8'h7E, pe: 1'b0, fe: 1'b0});
      send_frame(8'h7E, 1'b0, 1'b0, 1'b1);
      step(40);
      checks++;
      if (!got) begin
         errors++; $display("FAIL midrst_timeout got=no_valid exp=valid");
      end else begin
         e = q.pop_front();
         checks++; if (cap_d !== e.d) begin errors++; $display("FAIL midrst_data_after got=%h exp=%h", cap_d, e.d); end
         checks++; if (cap_fe !== e.fe) begin errors++; $display("FAIL midrst_ferr_after got=%b exp=%b", cap_fe, e.fe); end
      end
   endtask

   initial begin
      rst = 1'b1;
      rx = 1'b1; rx_p = 1'b1;
      data_ready = 1'b1; overrun_clr = 1'b0;
      data_ready_p = 1'b1; overrun_clr_p = 1'b0;
      sel = 1'b0; got = 1'b0; vcount = 0;
      cap_d = '0; cap_pe = 1'b0; cap_fe = 1'b0;
      test_reset();
      test_basic();
      test_parity();
      test_frame_err();
      test_false_start();
      test_back_to_back();
      test_reset_midframe();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 The block SHALL have these parameters:
- CLK_HZ, 66_000_000, system clock frequency.
- BAUD, 9_600, line bit rate.
- DATA_BITS, 8, payload width; legal range 5..9.
- PARITY, 0, parity mode: 0 none, 1 odd, 2 even.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.
REQ-002 The block SHALL have these ports, clock and reset first:
- clk  in  1  system clock; rising edge active.
- rst  in  1  asynchronous, active-high reset.
- rx  in  1  serial line; idles high; asynchronous to clk.
- data  out  DATA_BITS  received payload, LSB received first.
- data_valid  out  1  payload available; held until accepted.
- data_ready  in  1  consumer accepts the payload when data_valid=1 and data_ready=1.
- parity_err  out  1  parity mismatch on the current payload; valid while data_valid=1.
- frame_err  out  1  a stop bit was sampled low; valid while data_valid=1.
- overrun  out  1  sticky: a frame completed while data_valid was still 1.
- overrun_clr  in  1  clears overrun.

Function
REQ-003 rx SHALL pass through a 2-flop synchronizer; all logic SHALL use only the synchronized value rx_s.
REQ-004 A tick divider SHALL emit a 1-cycle tick every DIV = round(CLK_HZ/(BAUD*16)) clocks.
REQ-005 Elaboration SHALL fail if DIV < 2, DATA_BITS is outside 5..9, PARITY > 2, or STOP_BITS is not 1 or 2.
REQ-006 The FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-007 IDLE: the FSM SHALL go to START on a 1-to-0 transition of rx_s, and SHALL restart the tick divider and the 0..15 sub-bit counter at that point.
REQ-008 Each bit SHALL be sampled as the 2-of-3 majority of rx_s at sub-bit ticks 7, 8 and 9; the bit decision SHALL be taken at tick 9.
REQ-009 START: if the majority value is 1, the FSM SHALL return to IDLE (false start) with no outputs changed; otherwise it SHALL enter DATA at tick 15.
REQ-010 DATA: the FSM SHALL collect DATA_BITS samples, LSB first, into a shift register.
- After the last bit it SHALL go to PARITY if PARITY != 0, else to STOP.
REQ-011 PARITY: parity_calc SHALL be XOR of the payload bits XOR the parity bit.
- Error condition: parity_calc = 0 for odd mode, parity_calc = 1 for even mode.
REQ-012 STOP: the FSM SHALL sample STOP_BITS stop bits; any stop bit sampled 0 SHALL set frame_err for that frame.
REQ-013 On the decision tick of the last stop bit:
- data, parity_err and frame_err SHALL load in the same cycle, and data_valid SHALL rise in the next cycle.
- The FSM SHALL return to IDLE immediately, without waiting for the bit end.
REQ-014 A frame with frame_err=1 SHALL still be delivered.
- If rx_s is low at the return to IDLE, no new start SHALL be detected until rx_s has first gone high.
REQ-015 data_valid SHALL fall in the cycle after a data_valid and data_ready handshake; data, parity_err and frame_err SHALL be stable while data_valid=1.
REQ-016 If a frame completes while data_valid=1:
- the new frame SHALL overwrite data, parity_err and frame_err;
- data_valid SHALL stay 1;
- overrun SHALL be set.
REQ-017 If a frame completes in the same cycle as a handshake, the new frame SHALL load, data_valid SHALL stay 1, and overrun SHALL NOT be set.
REQ-018 overrun_clr SHALL clear overrun; if overrun_clr and a new overrun occur in the same cycle, the set SHALL win.
REQ-019 Reception SHALL continue independently of data_ready; the FSM SHALL never stall.

Reset
REQ-020 While rst=1, the block SHALL hold this state:
- FSM in IDLE; divider and counters at 0.
- Synchronizer flops at 1.
- data = 0, data_valid = 0, parity_err = 0, frame_err = 0, overrun = 0.
REQ-021 Asserting rst mid-frame SHALL abort the frame with no output pulse.
- After rst deasserts, the block SHALL need a fresh 1-to-0 edge on rx_s before it receives again.

Structure
REQ-022 A package uart_pkg SHALL hold:
- the state enum;
- the parity-mode localparams PAR_NONE, PAR_ODD, PAR_EVEN;
- the function computing DIV.
REQ-023 The tick divider SHALL be a sub-module uart_baud_tick (inputs clk, rst, restart; output tick).

Verification
Bench settings: CLK_HZ=1_600_000, BAUD=10_000, so DIV=10 and one bit = 160 clks.
REQ-024 8N1 frame 0xA5 with data_ready=1 -> data=0xA5; data_valid high for 1 cycle; no error flags.
REQ-025 PARITY=2, byte 0x03 sent with parity bit 1 -> parity_err=1 and data=0x03; same byte sent with parity bit 0 -> parity_err=0.
REQ-026 Stop bit driven 0 -> frame_err=1 and data delivered; next frame 0x55 after 2 bit-times of idle -> data=0x55, frame_err=0.
REQ-027 60-clk low glitch on an idle line -> false start: no data_valid and FSM back in IDLE.
REQ-028 Two frames 0x11, 0x22 sent back-to-back with data_ready=0 -> data=0x22, data_valid=1, overrun=1; overrun_clr pulse -> overrun=0.
REQ-029 rst asserted at bit 4 of a frame -> all outputs 0; next clean frame 0x7E -> data=0x7E.
